// File: rtl/button_event.sv
// Turns a clean, synchronous button level into one-cycle press/release/long-press/repeat
// events plus a wrapping step counter. The release pulse is named `released` (release is reserved).
module button_event #(
  parameter logic [23:0] LONG_CNT   = 24'd5_000_000,
  parameter logic [23:0] REPEAT_CNT = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       press,
  output logic       released,
  output logic       long_press,
  output logic       rpt,
  output logic       step,
  output logic       held,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  localparam logic [23:0] LONG_LAST   = LONG_CNT - 24'd1;
  localparam logic [23:0] REPEAT_LAST = REPEAT_CNT - 24'd1;

  state_t      state;
  logic [23:0] cnt;
  logic        rise;
  logic        fall;

  assign rise = btn_in & ~held;
  assign fall = ~btn_in & held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      held       <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      step       <= 1'b0;
      step_count <= '0;
    end else begin
      held       <= btn_in;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      step       <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            press      <= 1'b1;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
            cnt        <= '0;
            state      <= SHORT;
          end
        end
        SHORT: begin
          // Release is tested first so it wins over a coincident terminal count.
          if (fall) begin
            released <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            cnt        <= '0;
            state      <= LONG;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        LONG: begin
          if (fall) begin
            released <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else if (!repeat_en) begin
            cnt <= '0;
          end else if (cnt == REPEAT_LAST) begin
            rpt        <= 1'b1;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event (LONG_CNT=8, REPEAT_CNT=4): expected pulses are queued
// by cycle number when stimulus is driven and compared every cycle against the outputs.
module tb_button_event;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       repeat_en = 1'b0;
  logic       press, released, long_press, rpt, step, held;
  logic [7:0] step_count;

  button_event #(.LONG_CNT(24'd8), .REPEAT_CNT(24'd4)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
    .press(press), .released(released), .long_press(long_press), .rpt(rpt),
    .step(step), .held(held), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Event vector order: {press, released, long_press, rpt, step}
  localparam logic [4:0] EV_PS  = 5'b10001;
  localparam logic [4:0] EV_REL = 5'b01000;
  localparam logic [4:0] EV_LNG = 5'b00100;
  localparam logic [4:0] EV_RS  = 5'b00011;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t       sb[$];
  int         e;
  logic [7:0] sc_exp;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic push(input int cyc, input logic [4:0] ev);
    exp_t x;
    x.cyc = cyc;
    x.ev  = ev;
    sb.push_back(x);
  endtask

  // Advance one edge and compare outputs for cycle e+1 against the scoreboard.
  task automatic tick();
    logic [4:0] exp_ev;
    @(posedge clk);
    #1;
    e++;
    exp_ev = '0;
    if (sb.size() > 0 && sb[0].cyc == e + 1) begin
      exp_ev = sb[0].ev;
      void'(sb.pop_front());
      if (exp_ev[0]) sc_exp = sc_exp + 8'd1;
    end
    check("events", {3'b000, press, released, long_press, rpt, step}, {3'b000, exp_ev});
    check("step_count", step_count, sc_exp);
    check("held", {7'd0, held}, {7'd0, btn_in});
  endtask

  // Tick until the next clock edge is edge k.
  task automatic go_to(input int k);
    while (e < k - 1) tick();
  endtask

  task automatic start(input logic btn);
    rst    = 1'b1;
    btn_in = btn;
    @(posedge clk);
    #1;
    check("reset_events", {3'b000, press, released, long_press, rpt, step}, 8'd0);
    check("reset_count", step_count, 8'd0);
    check("reset_held", {7'd0, held}, 8'd0);
    #3;
    rst    = 1'b0;
    e      = 0;
    sc_exp = '0;
  endtask

  task automatic finish_scenario(input string tag);
    check({tag, "_queue_empty"}, sb.size()[7:0], 8'd0);
    sb.delete();
  endtask

  initial begin
    e      = 0;
    sc_exp = '0;

    // Short press
    repeat_en = 1'b0;
    start(1'b0);
    go_to(10); btn_in = 1'b1; push(11, EV_PS);
    go_to(14); btn_in = 1'b0; push(15, EV_REL);
    go_to(20);
    check("short_count", step_count, 8'd1);
    finish_scenario("short");

    // Long press with repeat; release at edge 30 collides with a repeat terminal count
    start(1'b0);
    repeat_en = 1'b1;
    go_to(10); btn_in = 1'b1;
    push(11, EV_PS); push(19, EV_LNG); push(23, EV_RS); push(27, EV_RS);
    go_to(30); btn_in = 1'b0; push(31, EV_REL);
    go_to(36);
    check("long_count", step_count, 8'd3);
    finish_scenario("long");

    // Repeat disabled, then re-enabled at edge 22 while held
    start(1'b0);
    repeat_en = 1'b0;
    go_to(10); btn_in = 1'b1; push(11, EV_PS); push(19, EV_LNG);
    go_to(22); repeat_en = 1'b1; push(26, EV_RS); push(30, EV_RS);
    go_to(32); btn_in = 1'b0; push(33, EV_REL);
    go_to(38);
    check("norpt_count", step_count, 8'd3);
    finish_scenario("norpt");

    // Release sampled where the SHORT counter reaches 7
    start(1'b0);
    repeat_en = 1'b1;
    go_to(10); btn_in = 1'b1; push(11, EV_PS);
    go_to(18); btn_in = 1'b0; push(19, EV_REL);
    go_to(24);
    finish_scenario("short_collide");

    // Release sampled at the LONG repeat boundary
    start(1'b0);
    repeat_en = 1'b1;
    go_to(10); btn_in = 1'b1; push(11, EV_PS); push(19, EV_LNG); push(23, EV_RS);
    go_to(26); btn_in = 1'b0; push(27, EV_REL);
    go_to(32);
    check("long_collide_count", step_count, 8'd2);
    finish_scenario("long_collide");

    // 256 one-cycle presses wrap step_count back to 0
    start(1'b0);
    repeat_en = 1'b0;
    go_to(3);
    for (int i = 0; i < 256; i++) begin
      btn_in = 1'b1; push(e + 2, EV_PS);
      tick();
      btn_in = 1'b0; push(e + 2, EV_REL);
      tick();
      tick();
    end
    tick(); tick();
    check("wrap_count", step_count, 8'd0);
    finish_scenario("wrap");

    // Asynchronous reset while long_press is high, button still held
    start(1'b0);
    repeat_en = 1'b1;
    go_to(10); btn_in = 1'b1; push(11, EV_PS); push(19, EV_LNG);
    go_to(19);
    check("pre_reset_long", {7'd0, long_press}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_events", {3'b000, press, released, long_press, rpt, step}, 8'd0);
    check("async_count", step_count, 8'd0);
    check("async_held", {7'd0, held}, 8'd0);
    finish_scenario("async");
    @(posedge clk);
    #4;
    rst    = 1'b0;
    e      = 0;
    sc_exp = '0;
    push(2, EV_PS);
    go_to(6);
    check("post_reset_count", step_count, 8'd1);
    finish_scenario("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Downstream consumer of the debounced button level. Converts one clean, synchronous level into single-cycle event pulses: press, release, long-press, and auto-repeat while held. It also keeps a running count of step events. Its outputs feed the memory-control front panel logic (address step, mode select), so every event is exactly one clock wide.

## Interface
- `LONG_CNT`, 24'd5_000_000, cycles held after press before `long_press` fires; must be ≥ 2
- `REPEAT_CNT`, 24'd1_000_000, cycles between auto-repeat pulses once in long-press; must be ≥ 2
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high; clears all state
- `btn_in`  in  1  debounced button level, already synchronous to `clk`; 1 = pressed
- `repeat_en`  in  1  1 = auto-repeat enabled while in long-press
- `press`  out  1  one-cycle pulse on a press
- `release`  out  1  one-cycle pulse on a release
- `long_press`  out  1  one-cycle pulse when the hold reaches `LONG_CNT`
- `rpt`  out  1  one-cycle auto-repeat pulse
- `step`  out  1  `press | rpt`, registered and coincident with them
- `held`  out  1  registered copy of `btn_in`
- `step_count`  out  8  count of `step` pulses; wraps 255 → 0

## Operation
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - all outputs 0
  - `held` = 0, `step_count` = 0
  - state IDLE, hold counter (24 bit) 0
- Edge detection compares the `btn_in` value sampled at an edge against `held`.
- Outputs are registered. Event pulses are high for exactly one cycle, the cycle after the deciding edge.
- States: IDLE, SHORT, LONG.
- IDLE:
  - On an edge with `btn_in`=1: `press`=1, `step`=1, counter ← 0, go to SHORT.
- SHORT:
  - Counter increments each cycle.
  - On the edge where counter == `LONG_CNT`−1 and `btn_in`=1: `long_press`=1, counter ← 0, go to LONG.
- LONG, with `repeat_en`=1:
  - Counter increments each cycle.
  - On the edge where counter == `REPEAT_CNT`−1: `rpt`=1, `step`=1, counter ← 0.
- LONG, with `repeat_en`=0:
  - Counter is held at 0 and no `rpt` is produced.
  - When `repeat_en` is reasserted, a full `REPEAT_CNT` interval runs before the next `rpt`.
- Release: in SHORT or LONG, an edge with `btn_in`=0 gives `release`=1, counter ← 0, go to IDLE.
- Simultaneous events: if release coincides with a terminal count, release wins. `long_press` and `rpt` are suppressed.
- `step_count` increments on the edge that sets `step`. It is visible the same cycle `step` is high.
- `btn_in` held high through reset deassertion produces `press` on the first sampling edge, because `held` resets to 0.
- `rst` asserted mid-operation clears everything at once. Any pulse in flight is cut short.
- Counter width is 24 bit. Terminal compares use `LONG_CNT`−1 and `REPEAT_CNT`−1 as 24-bit constants. No overflow is possible given the parameter limits.

## Timing
- Latency: `btn_in` change sampled at edge k → `press`/`release` high in cycle k+1; `held` updates at edge k.
- `long_press`: high exactly `LONG_CNT` cycles after `press` was high, if held throughout.
- First `rpt`: `REPEAT_CNT` cycles after `long_press`. Later ones every `REPEAT_CNT` cycles.
- Minimum press width: a press lasting 1 cycle gives `press` then `release` 1 cycle later.
- Pulses never overlap, with two exceptions: `step` coincides with `press`/`rpt`, and `release` may follow `press` on the very next cycle.

## Test plan
Parameters for all scenarios: `LONG_CNT`=8, `REPEAT_CNT`=4.
- Reset, then short press: assert `rst` with `btn_in`=0; release `rst`. Raise `btn_in` at edge 10, drop at edge 14 → `press`/`step` high in cycle 11, `release` high in cycle 15, no `long_press`, `step_count`=1.
- Long press with repeat: `repeat_en`=1, hold from edge 10 to edge 30 → `press` @11, `long_press` @19, `rpt`/`step` @23, @27, `release` @31, `step_count`=3.
- Repeat disabled: same stimulus as the long-press scenario, `repeat_en`=0 → `long_press` @19, no `rpt`, `step_count`=1. Then re-enable at edge 22 while held → next `rpt` 4 cycles later.
- Release collides with terminal count: release sampled on the edge where counter == 7 in SHORT → `release` only, no `long_press`. Same check for the LONG repeat boundary.
- Counter wrap: generate 256 short presses → `step_count` returns to 0. Each `press` is exactly one cycle.
- Async reset mid-LONG: assert `rst` between clock edges → all outputs 0 immediately. With `btn_in` still 1 after release of `rst`, `press` fires on the first edge.
